// File: rtl/hiscore_upload_reader_pkg.sv
// -----------------------------------------------------------------------------
// hiscore_pkg
// Shared definitions for the hiscore/NVRAM upload reader:
//   - state_t         : responder FSM states
//   - HS_DEF_PAD      : default byte returned for out-of-window reads
//   - HS_DEF_INDEX    : default ioctl_index that selects this block
//   - addr_in_window(): true when an HPS byte address maps into the RAM window
// -----------------------------------------------------------------------------
package hiscore_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PAUSE_WAIT = 3'd1,
        READY      = 3'd2,
        FETCH      = 3'd3,
        RELEASE    = 3'd4
    } state_t;

    localparam logic [7:0] HS_DEF_PAD   = 8'hFF;
    localparam logic [7:0] HS_DEF_INDEX = 8'd4;

    // An address is in-window only if every bit above the RAM address width is
    // zero and it is below the number of bytes actually served.
    function automatic logic addr_in_window(input logic [24:0] addr,
                                            input int unsigned aw,
                                            input int unsigned size);
        logic [31:0] a;
        a = {7'd0, addr};
        return ((a >> aw) == 32'd0) && (a < size);
    endfunction

endpackage

// File: rtl/hiscore_upload_reader_if.sv
// -----------------------------------------------------------------------------
// hiscore_upload_reader_if
// HPS upload (ioctl read) bus between hps_io and the upload reader.
//   ioctl_upload : high while the HPS runs an upload
//   ioctl_index  : upload target index
//   ioctl_rd     : one-cycle read strobe
//   ioctl_addr   : byte address qualified by ioctl_rd
//   ioctl_din    : byte returned to the HPS
// Handshake: ioctl_rd is a single-cycle strobe with no back-pressure; the
// address is only meaningful in the strobe cycle. The responder has no ready
// signal, so ioctl_din simply holds the last captured byte until the next
// capture and the HPS is expected to space strobes far enough apart.
// Modports: master = hps_io side, slave = upload reader side.
// -----------------------------------------------------------------------------
interface hiscore_upload_reader_if;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;

    modport master (
        output ioctl_upload,
        output ioctl_index,
        output ioctl_rd,
        output ioctl_addr,
        input  ioctl_din
    );

    modport slave (
        input  ioctl_upload,
        input  ioctl_index,
        input  ioctl_rd,
        input  ioctl_addr,
        output ioctl_din
    );
endinterface

// File: rtl/hiscore_upload_reader_delay_line.sv
// -----------------------------------------------------------------------------
// hs_delay_line
// DEPTH-deep valid shift register. A pulse on i_vld appears on o_vld exactly
// DEPTH cycles later; i_clr flushes every stage.
//   clk_sys : clock
//   reset_n : asynchronous active-low reset
//   i_clr   : synchronous flush
//   i_vld   : input pulse
//   o_vld   : delayed pulse
// -----------------------------------------------------------------------------
module hs_delay_line #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_vld,
    output logic o_vld
);

    logic [DEPTH-1:0] r_sr;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sr <= '0;
        end else if (i_clr) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_vld;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_vld = r_sr[DEPTH-1];

endmodule

// File: rtl/hiscore_upload_reader.sv
// -----------------------------------------------------------------------------
// hiscore_upload_reader
// Core-side responder for the hps_io upload direction. While an upload with
// the matching index is active it pauses the CPU, waits for the bus to settle,
// takes over the work-RAM read port and answers HPS read strobes with RAM
// bytes (or PAD outside the window).
// Ports:
//   clk_sys, reset_n : clock, asynchronous active-low reset
//   hps              : ioctl upload bus (slave side)
//   pause_req        : CPU pause request
//   paused           : CPU halted acknowledge
//   ram_sel          : 1 = this block owns the work-RAM read port
//   ram_addr         : work-RAM read address
//   ram_q            : work-RAM read data
//   busy             : high from upload accept until release completes
//   o_dbg_state      : current FSM state
//   o_dbg_overrun    : a strobe was dropped because one was already pending
// -----------------------------------------------------------------------------
module hiscore_upload_reader
    import hiscore_pkg::*;
#(
    parameter int unsigned AW     = 10,
    parameter int unsigned SIZE   = 1024,
    parameter logic [7:0]  INDEX  = HS_DEF_INDEX,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned SETTLE = 16,
    parameter logic [7:0]  PAD    = HS_DEF_PAD
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    hiscore_upload_reader_if.slave hps,
    output logic                  pause_req,
    input  logic                  paused,
    output logic                  ram_sel,
    output logic [AW-1:0]         ram_addr,
    input  logic [7:0]            ram_q,
    output logic                  busy,
    output state_t                o_dbg_state,
    output logic                  o_dbg_overrun
);

    // Wide enough for SETTLE-1 and for the two-step release sequence.
    localparam int CW = $clog2(SETTLE + 2);

    state_t          r_state;
    logic            r_active_q;
    logic [CW-1:0]   r_cnt;
    logic            r_pend;
    logic [24:0]     r_pend_addr;
    logic            r_overrun;
    logic            r_addr_vld;
    logic [7:0]      r_din;
    logic            r_pause_req;
    logic            r_ram_sel;
    logic [AW-1:0]   r_ram_addr;
    logic            r_busy;

    logic            w_active;
    logic            w_fall;
    logic            w_abort;
    logic            w_req;
    logic [24:0]     w_req_addr;
    logic            w_req_win;
    logic            w_cap;
    logic            w_clr;

    assign w_active = hps.ioctl_upload && (hps.ioctl_index == INDEX);
    assign w_fall   = r_active_q && !w_active;
    // A falling edge while idle or already releasing needs no action.
    assign w_abort  = w_fall && (r_state != IDLE) && (r_state != RELEASE);

    // A pending strobe is older than a fresh one, so it is served first.
    assign w_req      = r_pend || hps.ioctl_rd;
    assign w_req_addr = r_pend ? r_pend_addr : hps.ioctl_addr;
    assign w_req_win  = addr_in_window(w_req_addr, AW, SIZE);

    assign w_clr = (r_state == RELEASE);

    // r_addr_vld marks the cycle a new address sits on the RAM port; after
    // RD_LAT more cycles the RAM data is valid and is captured on the next edge.
    hs_delay_line #(
        .DEPTH (RD_LAT)
    ) u_delay (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_clr   (w_clr),
        .i_vld   (r_addr_vld),
        .o_vld   (w_cap)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_active_q  <= 1'b0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_overrun   <= 1'b0;
            r_addr_vld  <= 1'b0;
            r_din       <= 8'h00;
            r_pause_req <= 1'b0;
            r_ram_sel   <= 1'b0;
            r_ram_addr  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_active_q <= w_active;
            r_addr_vld <= 1'b0;
            if (w_abort) begin
                // Any in-flight fetch is dropped; its capture is ignored.
                r_state   <= RELEASE;
                r_ram_sel <= 1'b0;
                r_cnt     <= '0;
                r_pend    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        // Level test here: a rise seen during RELEASE is
                        // still honoured once IDLE is reached.
                        if (w_active) begin
                            r_state     <= PAUSE_WAIT;
                            r_pause_req <= 1'b1;
                            r_busy      <= 1'b1;
                            r_cnt       <= '0;
                            r_overrun   <= 1'b0;
                            r_pend      <= hps.ioctl_rd;
                            r_pend_addr <= hps.ioctl_addr;
                        end
                    end
                    PAUSE_WAIT: begin
                        if (hps.ioctl_rd) begin
                            if (r_pend) begin
                                r_overrun <= 1'b1;
                            end else begin
                                r_pend      <= 1'b1;
                                r_pend_addr <= hps.ioctl_addr;
                            end
                        end
                        if (!paused) begin
                            r_cnt <= '0;
                        end else if (r_cnt == CW'(SETTLE - 1)) begin
                            r_state   <= READY;
                            r_ram_sel <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    READY: begin
                        if (w_req) begin
                            if (w_req_win) begin
                                r_ram_addr <= w_req_addr[AW-1:0];
                                r_addr_vld <= 1'b1;
                                r_state    <= FETCH;
                            end else begin
                                r_din <= PAD;
                            end
                            // Serving the pending one while a new strobe
                            // arrives: the new strobe becomes the pending one.
                            if (r_pend && hps.ioctl_rd) begin
                                r_pend_addr <= hps.ioctl_addr;
                            end else begin
                                r_pend <= 1'b0;
                            end
                        end
                    end
                    FETCH: begin
                        if (hps.ioctl_rd) begin
                            if (r_pend) begin
                                r_overrun <= 1'b1;
                            end else begin
                                r_pend      <= 1'b1;
                                r_pend_addr <= hps.ioctl_addr;
                            end
                        end
                        if (w_cap) begin
                            r_din   <= ram_q;
                            r_state <= READY;
                        end
                    end
                    RELEASE: begin
                        // ram_sel already dropped; then pause_req, then busy.
                        if (r_cnt == '0) begin
                            r_pause_req <= 1'b0;
                            r_cnt       <= CW'(1);
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign hps.ioctl_din = r_din;
    assign pause_req     = r_pause_req;
    assign ram_sel       = r_ram_sel;
    assign ram_addr      = r_ram_addr;
    assign busy          = r_busy;
    assign o_dbg_state   = r_state;
    assign o_dbg_overrun = r_overrun;

endmodule

// File: tb/tb_hiscore_upload_reader.sv
// -----------------------------------------------------------------------------
// tb_hiscore_upload_reader
// Directed bench for hiscore_upload_reader: a table of single reads in READY
// plus hand-written sequences for pause/settle, pending/overrun, release and
// reset corner cases. A 1-cycle-latency work RAM is modelled here.
// -----------------------------------------------------------------------------
module tb_hiscore_upload_reader;
    import hiscore_pkg::*;

    localparam int unsigned SETTLE = 16;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       paused;
    logic       pause_req;
    logic       ram_sel;
    logic       busy;
    logic       overrun;
    logic [9:0] ram_addr;
    logic [7:0] ram_q;
    state_t     dbg_state;
    logic [7:0] mem [0:1023];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  exp_din;
        logic [9:0]  exp_ram_addr;
    } vec_t;

    vec_t vecs [8];

    always #5 clk_sys = ~clk_sys;

    hiscore_upload_reader_if hps_if ();

    hiscore_upload_reader #(
        .AW     (10),
        .SIZE   (1024),
        .INDEX  (8'd4),
        .RD_LAT (1),
        .SETTLE (SETTLE),
        .PAD    (8'hFF)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .hps           (hps_if),
        .pause_req     (pause_req),
        .paused        (paused),
        .ram_sel       (ram_sel),
        .ram_addr      (ram_addr),
        .ram_q         (ram_q),
        .busy          (busy),
        .o_dbg_state   (dbg_state),
        .o_dbg_overrun (overrun)
    );

    // Work RAM: one cycle read latency.
    always @(posedge clk_sys) ram_q <= mem[ram_addr];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_upload(input logic up, input logic [7:0] idx);
        hps_if.ioctl_upload = up;
        hps_if.ioctl_index  = idx;
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_din"},       32'(hps_if.ioctl_din), 32'h00);
        check({tag, "_pause_req"}, 32'(pause_req),        32'd0);
        check({tag, "_ram_sel"},   32'(ram_sel),          32'd0);
        check({tag, "_ram_addr"},  32'(ram_addr),         32'd0);
        check({tag, "_busy"},      32'(busy),             32'd0);
        check({tag, "_state"},     32'(dbg_state),        32'(IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h010] = 8'hA5;
        mem[10'h000] = 8'h3C;
        mem[10'h3FF] = 8'hC3;
        mem[10'h155] = 8'h69;

        vecs[0] = '{25'h0000010, 8'hA5, 10'h010};
        vecs[1] = '{25'h0000000, 8'h3C, 10'h000};
        vecs[2] = '{25'h00003FF, 8'hC3, 10'h3FF};
        vecs[3] = '{25'h0000400, 8'hFF, 10'h3FF};
        vecs[4] = '{25'h0000155, 8'h69, 10'h155};
        vecs[5] = '{25'h1000010, 8'hFF, 10'h155};
        vecs[6] = '{25'h0000410, 8'hFF, 10'h155};
        vecs[7] = '{25'h0000010, 8'hA5, 10'h010};

        // Clock/reset
        reset_n = 1'b0;
        paused  = 1'b0;
        set_upload(1'b0, 8'd0);
        hps_if.ioctl_rd   = 1'b0;
        hps_if.ioctl_addr = '0;
        #2;
        check_all_reset("rst");
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Foreign index never pauses
        set_upload(1'b1, 8'd0);
        repeat (4) tick();
        check("idx0_pause_req", 32'(pause_req), 32'd0);
        check("idx0_busy",      32'(busy),      32'd0);
        check("idx0_state",     32'(dbg_state), 32'(IDLE));
        set_upload(1'b0, 8'd0);
        tick();

        // Session 1: accept, pause after 3 cycles, settle
        set_upload(1'b1, 8'd4);
        tick();
        check("acc_pause_req", 32'(pause_req), 32'd1);
        check("acc_busy",      32'(busy),      32'd1);
        check("acc_ram_sel",   32'(ram_sel),   32'd0);
        check("acc_state",     32'(dbg_state), 32'(PAUSE_WAIT));
        tick();
        tick();
        paused = 1'b1;
        for (int i = 1; i <= int'(SETTLE); i++) begin
            tick();
            check("settle_ram_sel", 32'(ram_sel), 32'(i == int'(SETTLE)));
        end
        check("settle_pause_req", 32'(pause_req), 32'd1);
        check("settle_state",     32'(dbg_state), 32'(READY));

        // First read latency: valid 2 cycles after the strobe
        hps_if.ioctl_rd   = 1'b1;
        hps_if.ioctl_addr = 25'h010;
        tick();
        hps_if.ioctl_rd = 1'b0;
        tick();
        check("lat_e1_din", 32'(hps_if.ioctl_din), 32'h00);
        tick();
        check("lat_e2_din", 32'(hps_if.ioctl_din), 32'hA5);
        tick();
        tick();

        // Address == SIZE: PAD on the next cycle, RAM address untouched
        hps_if.ioctl_rd   = 1'b1;
        hps_if.ioctl_addr = 25'h400;
        tick();
        hps_if.ioctl_rd = 1'b0;
        tick();
        check("pad_din",      32'(hps_if.ioctl_din), 32'hFF);
        check("pad_ram_addr", 32'(ram_addr),         32'h010);
        repeat (3) tick();

        // Table of single reads
        for (int v = 0; v < 8; v++) begin
            hps_if.ioctl_rd   = 1'b1;
            hps_if.ioctl_addr = vecs[v].addr;
            tick();
            hps_if.ioctl_rd = 1'b0;
            tick();
            tick();
            check($sformatf("vec%0d_din", v),      32'(hps_if.ioctl_din), 32'(vecs[v].exp_din));
            check($sformatf("vec%0d_ram_addr", v), 32'(ram_addr),         32'(vecs[v].exp_ram_addr));
            check($sformatf("vec%0d_state", v),    32'(dbg_state),        32'(READY));
            tick();
            tick();
        end

        // Strobe during FETCH is pended; a third one overruns
        check("ovr_before", 32'(overrun), 32'd0);
        hps_if.ioctl_rd   = 1'b1;
        hps_if.ioctl_addr = 25'h3FF;
        tick();
        hps_if.ioctl_addr = 25'h155;
        tick();
        hps_if.ioctl_addr = 25'h010;
        tick();
        hps_if.ioctl_rd = 1'b0;
        check("pend_first_din", 32'(hps_if.ioctl_din), 32'hC3);
        check("pend_overrun",   32'(overrun),          32'd1);
        check("pend_state_rdy", 32'(dbg_state),        32'(READY));
        tick();
        check("pend_ram_addr",  32'(ram_addr),  32'h155);
        check("pend_state_fch", 32'(dbg_state), 32'(FETCH));
        tick();
        tick();
        check("pend_served_din", 32'(hps_if.ioctl_din), 32'h69);
        repeat (4) tick();
        check("drop_din",      32'(hps_if.ioctl_din), 32'h69);
        check("drop_ram_addr", 32'(ram_addr),         32'h155);

        // Upload falls mid-FETCH
        hps_if.ioctl_rd   = 1'b1;
        hps_if.ioctl_addr = 25'h000;
        tick();
        hps_if.ioctl_rd = 1'b0;
        set_upload(1'b0, 8'd4);
        check("rel_in_fetch", 32'(dbg_state), 32'(FETCH));
        tick();
        check("rel1_ram_sel",   32'(ram_sel),   32'd0);
        check("rel1_pause_req", 32'(pause_req), 32'd1);
        check("rel1_busy",      32'(busy),      32'd1);
        paused = 1'b0;
        tick();
        check("rel2_pause_req", 32'(pause_req), 32'd0);
        check("rel2_busy",      32'(busy),      32'd1);
        tick();
        check("rel3_busy",  32'(busy),             32'd0);
        check("rel3_din",   32'(hps_if.ioctl_din), 32'h69);
        check("rel3_state", 32'(dbg_state),        32'(IDLE));

        // Session 2: strobe during PAUSE_WAIT is served once READY
        set_upload(1'b1, 8'd4);
        tick();
        paused            = 1'b1;
        hps_if.ioctl_rd   = 1'b1;
        hps_if.ioctl_addr = 25'h010;
        tick();
        hps_if.ioctl_rd = 1'b0;
        repeat (SETTLE + 1) tick();
        check("pw_rd_not_yet", 32'(hps_if.ioctl_din), 32'h69);
        check("pw_rd_ram_sel", 32'(ram_sel),          32'd1);
        tick();
        check("pw_rd_din", 32'(hps_if.ioctl_din), 32'hA5);
        tick();
        tick();

        // Reset pulse mid-READY clears outputs asynchronously
        check("pre_rst_state", 32'(dbg_state), 32'(READY));
        reset_n = 1'b0;
        #1;
        check_all_reset("async_rst");
        set_upload(1'b0, 8'd0);
        paused = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_state",     32'(dbg_state), 32'(IDLE));
        check("post_rst_pause_req", 32'(pause_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
